// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one 3-bit-per-cycle serial parity datapath across NUM_REQ requesters.
// Optional result counter output res_count is enabled with `define PARITY_ARB_CNT_EN.
module parity_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned PARITY_ODD = 0,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_parity,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
`ifdef PARITY_ARB_CNT_EN
  ,
  output logic [15:0]               res_count
`endif
);

  localparam int unsigned STEPS = DATA_W / 3;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  state_t              state_nx;
  logic [DATA_W-1:0]   shreg;
  logic                acc;
  logic [CNT_W-1:0]    cnt;
  logic [ID_W-1:0]     rr_ptr;

  logic [DATA_W-1:0]   words [NUM_REQ];
  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     next_ptr;
  logic [ID_W-1:0]     idx;
  logic                found;
  logic                hs;
  logic                res_hs;
  logic                acc_final;

  // First valid requester at or after rr_ptr, wrapping around
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_W +: DATA_W];
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found         = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

  assign next_ptr  = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
  assign req_ready = (state == IDLE && !rst) ? grant_oh : '0;
  assign hs        = (state == IDLE) && !rst && found;
  assign res_hs    = (state == DONE) && res_ready;
  assign acc_final = acc ^ (^shreg[2:0]);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture on grant, fold 3 bits per cycle, hold result through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      acc        <= 1'b0;
      cnt        <= '0;
      rr_ptr     <= '0;
      res_parity <= 1'b0;
      res_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            shreg  <= words[grant_idx];
            res_id <= grant_idx;
            acc    <= 1'b0;
            cnt    <= CNT_W'(STEPS - 1);
            rr_ptr <= next_ptr;
          end
        end
        SHIFT: begin
          acc   <= acc_final;
          shreg <= shreg >> 3;
          if (cnt == '0) res_parity <= acc_final ^ 1'(PARITY_ODD);
          else           cnt        <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PARITY_ARB_CNT_EN
  // Saturating count of consumed results
  always_ff @(posedge clk) begin
    if (rst)                               res_count <= '0;
    else if (res_hs && res_count != 16'hFFFF) res_count <= res_count + 16'd1;
  end
`else
  logic unused_res_hs;
  assign unused_res_hs = res_hs;
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// Scoreboard bench for parity_arbiter: driver pushes expected {id, parity}, monitor pops on result handshakes.
module tb_parity_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 12;
`ifdef PARITY_ARB_CNT_EN
  localparam int unsigned PODD = 1;
`else
  localparam int unsigned PODD = 0;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic       parity;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic                      res_parity;
  logic [1:0]                res_id;
  logic                      busy;
`ifdef PARITY_ARB_CNT_EN
  logic [15:0]               res_count;
`endif

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   popped   = 0;

  // Hand-computed even parities: 003->0, 007->1, A5A->0, 0F1->1
  logic [DATA_W-1:0] word [NUM_REQ] = '{12'h003, 12'h007, 12'hA5A, 12'h0F1};
  int unsigned       pbase [NUM_REQ] = '{0, 1, 0, 1};

  always #5 clk = ~clk;

  parity_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PARITY_ODD(PODD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_parity (res_parity),
    .res_id     (res_id),
    .busy       (busy)
`ifdef PARITY_ARB_CNT_EN
    ,
    .res_count  (res_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int unsigned id, input int unsigned p);
    exp_t e;
    e.id     = 2'(id);
    e.parity = 1'(p);
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input int unsigned i, input logic [DATA_W-1:0] w);
    req_data[i*DATA_W +: DATA_W] = w;
  endtask

  task automatic put_all();
    for (int i = 0; i < int'(NUM_REQ); i++) put(i, word[i]);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      if (res_valid) break;
    end
    chk(name, 32'(res_valid), 32'd1);
  endtask

  task automatic wait_grant(output logic [NUM_REQ-1:0] gr);
    gr = req_ready;
    for (int i = 0; i < 20 && gr == '0; i++) begin
      tick();
      #1;
      gr = req_ready;
    end
  endtask

  // Monitor: any result must be expected; pop on the handshake cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (res_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got res_valid=1 id=%0d expected no result", res_id);
        end else if (res_ready) begin
          e = q.pop_front();
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_parity", 32'(res_parity), 32'(e.parity));
          popped++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] gr;
    rst       = 1'b1;
    req_valid = '1;
    req_data  = '0;
    res_ready = 1'b0;

    // Reset values, req_ready gated while rst is high
    repeat (2) tick();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_parity", 32'(res_parity), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single word 001 from requester 0, check latency
    tick();
    rst = 1'b0;
    put(0, 12'h001);
    req_valid = 4'b0001;
    #1;
    chk("single_grant", 32'(req_ready), 32'b0001);
    q.push_back(mk(0, 1 ^ PODD));
    tick();
    req_valid = '0;
    #1;
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_res_valid_t0", 32'(res_valid), 32'd0);
    repeat (3) begin
      tick();
      #1;
      chk("single_latency_low", 32'(res_valid), 32'd0);
    end
    tick();
    #1;
    chk("single_latency_high", 32'(res_valid), 32'd1);

    // Backpressure: result must hold while res_ready is low
    repeat (10) begin
      tick();
      req_valid = '1;
      #1;
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_parity", 32'(res_parity), 32'(1 ^ PODD));
      chk("bp_id", 32'(res_id), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    tick();
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    chk("bp_release_valid", 32'(res_valid), 32'd1);
    tick();
    res_ready = 1'b0;
    #1;
    chk("bp_done_busy", 32'(busy), 32'd0);
    chk("bp_done_valid", 32'(res_valid), 32'd0);

    // All-ones word from requester 2
    tick();
    put(2, 12'hFFF);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    #1;
    chk("ones_grant", 32'(req_ready), 32'b0100);
    q.push_back(mk(2, 0 ^ PODD));
    tick();
    req_valid = '0;
    wait_valid("ones_result_valid");
    tick();
    #1;
    chk("ones_busy_low", 32'(busy), 32'd0);

    // Round robin from a fresh pointer, all valids held high
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    put_all();
    tick();
    req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      wait_grant(gr);
      chk("rr_grant", 32'(gr), 32'(1 << (g % 4)));
      q.push_back(mk(g % 4, pbase[g % 4] ^ PODD));
      tick();
      if (g == 4) req_valid = '0;
      #1;
    end
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    chk("rr_drained", 32'(q.size()), 32'd0);

    // Reset two cycles after a grant discards the word
    tick();
    tick();
    #1;
    chk("mid_idle", 32'(busy), 32'd0);
    req_valid = 4'b1000;
    #1;
    chk("mid_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_busy_low", 32'(busy), 32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_res_parity", 32'(res_parity), 32'd0);
    chk("mid_res_id", 32'(res_id), 32'd0);
    repeat (8) tick();
    #1;
    chk("mid_no_result", 32'(res_valid), 32'd0);
    tick();
    req_valid = '1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b0001);
    q.push_back(mk(0, pbase[0] ^ PODD));
    tick();
    req_valid = '0;
    wait_valid("post_rst_result");

    // Zero word: parity equals the odd/even selector
    tick();
    tick();
    put(1, 12'h000);
    req_valid = 4'b0010;
    #1;
    chk("zero_grant", 32'(req_ready), 32'b0010);
    q.push_back(mk(1, PODD));
    tick();
    req_valid = '0;
    wait_valid("zero_result");
    tick();
    tick();
    #1;
    chk("final_drained", 32'(q.size()), 32'd0);
    chk("final_popped", 32'(popped), 32'd9);
`ifdef PARITY_ARB_CNT_EN
    // Two results consumed since the last reset
    chk("res_count", 32'(res_count), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
